// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and constants for the interrupt controller
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISPATCH
    } intc_state_e;

    localparam logic REG_IF = 1'b0;
    localparam logic REG_IE = 1'b1;

    localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0040;
    localparam int          DEF_VECTOR_STRIDE = 8;

    // Dispatch address; 16-bit arithmetic wraps on overflow.
    function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                                input logic [15:0] stride,
                                                input logic [7:0]  idx);
        return base + 16'(idx) * stride;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - lowest-set-bit index of a request vector
module priority_encoder #(
    parameter int NUM_IRQ = 5,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - IF/IE/IME registers and request/ack/vector dispatch
// Optional INTC_DISPATCH_CANCEL_EN: re-select the channel at vector fetch.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_IRQ       = 5,
    parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter int          VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Enable,
    input  logic [NUM_IRQ-1:0] i_Irq_Pulse,
    input  logic               i_Reg_Sel,
    input  logic               i_Reg_Write,
    input  logic               i_Reg_Read,
    input  logic [7:0]         i_Reg_Data,
    output logic [7:0]         o_Reg_Data,
    input  logic               i_EI,
    input  logic               i_DI,
    input  logic               i_RETI,
    input  logic               i_Instr_Done,
    output logic               o_IME,
    output logic [NUM_IRQ-1:0] o_Pending,
    output logic               o_Wake,
    output logic               o_Irq_Req,
    input  logic               i_Ack,
    input  logic               i_Vector_Fetch,
    output logic [15:0]        o_Vector,
    output logic               o_Vector_Valid
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] if_reg, ie_reg, if_nxt, clr_mask;
    logic               ime, ei_pending;
    intc_state_e        state, state_nxt;
    logic [IDX_W-1:0]   enc_idx, disp_idx;
    logic               enc_valid, disp_hit;
    logic               ack_take, fetch_take;
    logic [15:0]        vector_nxt;
    logic [7:0]         rd_data;

    assign o_Pending = if_reg & ie_reg;
    assign o_Wake    = |o_Pending;
    assign o_IME     = ime;
    assign o_Irq_Req = (state == REQ);

    priority_encoder #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_enc (
        .req   (o_Pending),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

`ifdef INTC_DISPATCH_CANCEL_EN
    assign disp_idx = enc_idx;
    assign disp_hit = enc_valid;
`else
    logic [IDX_W-1:0] idx_reg;
    assign disp_idx = idx_reg;
    assign disp_hit = 1'b1;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)                       idx_reg <= '0;
        else if (i_Enable && ack_take)   idx_reg <= enc_idx;
    end
`endif

    assign vector_nxt = disp_hit ? vector_addr(VECTOR_BASE, 16'(VECTOR_STRIDE), 8'(disp_idx))
                                 : 16'h0000;
    assign clr_mask   = (fetch_take && disp_hit) ? (NUM_IRQ'(1) << disp_idx) : '0;

    always_comb begin
        state_nxt  = state;
        ack_take   = 1'b0;
        fetch_take = 1'b0;
        case (state)
            IDLE:     if (ime && enc_valid) state_nxt = REQ;
            REQ: begin
                if (!ime || !enc_valid) begin
                    state_nxt = IDLE;
                end else if (i_Ack) begin
                    ack_take  = 1'b1;
                    state_nxt = DISPATCH;
                end
            end
            DISPATCH: begin
                if (i_Vector_Fetch) begin
                    fetch_take = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Per-bit IF priority: pulse over dispatch clear over register write.
    always_comb begin
        if_nxt = if_reg;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i_Irq_Pulse[i])                           if_nxt[i] = 1'b1;
            else if (clr_mask[i])                         if_nxt[i] = 1'b0;
            else if (i_Reg_Write && i_Reg_Sel == REG_IF)  if_nxt[i] = i_Reg_Data[i];
        end
    end

    for (genvar b = 0; b < 8; b++) begin : g_rd
        if (b < NUM_IRQ) begin : g_impl
            assign rd_data[b] = (i_Reg_Sel == REG_IE) ? ie_reg[b] : if_reg[b];
        end else begin : g_fill
            assign rd_data[b] = (i_Reg_Sel == REG_IF);
        end
    end

    if (NUM_IRQ < 8) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^i_Reg_Data[7:NUM_IRQ];
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state          <= IDLE;
            if_reg         <= '0;
            ie_reg         <= '0;
            ime            <= 1'b0;
            ei_pending     <= 1'b0;
            o_Reg_Data     <= 8'h00;
            o_Vector       <= 16'h0000;
            o_Vector_Valid <= 1'b0;
        end else begin
            // The valid strobe never stretches, even across a stalled cycle.
            o_Vector_Valid <= 1'b0;
            if (i_Enable) begin
                state  <= state_nxt;
                if_reg <= if_nxt;
                if (i_Reg_Write && i_Reg_Sel == REG_IE) ie_reg <= i_Reg_Data[NUM_IRQ-1:0];
                if (i_Reg_Read) o_Reg_Data <= rd_data;
                if (i_DI) begin
                    ime        <= 1'b0;
                    ei_pending <= 1'b0;
                end else begin
                    if (i_EI) begin
                        ei_pending <= 1'b1;
                    end else if (ei_pending && i_Instr_Done) begin
                        ime        <= 1'b1;
                        ei_pending <= 1'b0;
                    end
                    if (i_RETI) ime <= 1'b1;
                    if (ack_take) ime <= 1'b0;
                end
                if (fetch_take) begin
                    o_Vector       <= vector_nxt;
                    o_Vector_Valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - table-driven self-checking bench for interrupt_controller
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [4:0]  pulse;
    logic        sel, wr, rd;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ei, di, reti, idone;
    logic        ime;
    logic [4:0]  pend;
    logic        wake, req, ack, fetch;
    logic [15:0] vec;
    logic        vv;

    int checks = 0;
    int failures = 0;

`ifdef INTC_DISPATCH_CANCEL_EN
    localparam logic [15:0] CAN_VEC = 16'h0000;
    localparam logic [7:0]  CAN_RD  = 8'hE9;
`else
    localparam logic [15:0] CAN_VEC = 16'h0040;
    localparam logic [7:0]  CAN_RD  = 8'hE8;
`endif

    always #5 clk = ~clk;

    interrupt_controller dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Enable       (en),
        .i_Irq_Pulse    (pulse),
        .i_Reg_Sel      (sel),
        .i_Reg_Write    (wr),
        .i_Reg_Read     (rd),
        .i_Reg_Data     (wdata),
        .o_Reg_Data     (rdata),
        .i_EI           (ei),
        .i_DI           (di),
        .i_RETI         (reti),
        .i_Instr_Done   (idone),
        .o_IME          (ime),
        .o_Pending      (pend),
        .o_Wake         (wake),
        .o_Irq_Req      (req),
        .i_Ack          (ack),
        .i_Vector_Fetch (fetch),
        .o_Vector       (vec),
        .o_Vector_Valid (vv)
    );

    // strb = {ei, di, reti, instr_done}; hs = {ack, vector_fetch}
    typedef struct {
        logic        en;
        logic [4:0]  pulse;
        logic        sel, wr, rd;
        logic [7:0]  wdata;
        logic [3:0]  strb;
        logic [1:0]  hs;
        logic        x_req, x_ime;
        logic [4:0]  x_pend;
        logic        x_vv;
        logic [15:0] x_vec;
        logic [7:0]  x_rd;
    } vec_t;

    vec_t rows[30];
    vec_t hand[6];

    task automatic idle_inputs();
        en = 1'b1; pulse = '0; sel = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
        ei = 1'b0; di = 1'b0; reti = 1'b0; idone = 1'b0; ack = 1'b0; fetch = 1'b0;
    endtask

    task automatic check_outputs(input string name, input logic [32:0] exp);
        logic [32:0] got;
        got = {req, ime, pend, wake, vv, vec, rdata};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got req=%0b ime=%0b pend=%h wake=%0b vv=%0b vec=%h rd=%h exp req=%0b ime=%0b pend=%h wake=%0b vv=%0b vec=%h rd=%h",
                     name, got[32], got[31], got[30:26], got[25], got[24], got[23:8], got[7:0],
                     exp[32], exp[31], exp[30:26], exp[25], exp[24], exp[23:8], exp[7:0]);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        en = v.en; pulse = v.pulse; sel = v.sel; wr = v.wr; rd = v.rd; wdata = v.wdata;
        {ei, di, reti, idone} = v.strb;
        {ack, fetch} = v.hs;
        @(posedge clk);
        @(negedge clk);
        check_outputs(name, {v.x_req, v.x_ime, v.x_pend, |v.x_pend, v.x_vv, v.x_vec, v.x_rd});
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //         en pulse  sel wr rd wdata strb     hs     req ime pend  vv vec       rd
        rows[0]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0000, 8'h00};
        rows[1]  = '{1, 5'h00, 1, 1, 0, 8'h1F, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0000, 8'h00};
        rows[2]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b1001, 2'b00, 0, 0, 5'h00, 0, 16'h0000, 8'h00};
        rows[3]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0000, 8'h00};
        rows[4]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0001, 2'b00, 0, 1, 5'h00, 0, 16'h0000, 8'h00};
        rows[5]  = '{1, 5'h14, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 0, 1, 5'h14, 0, 16'h0000, 8'h00};
        rows[6]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 1, 1, 5'h14, 0, 16'h0000, 8'h00};
        rows[7]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b10, 0, 0, 5'h14, 0, 16'h0000, 8'h00};
        rows[8]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b01, 0, 0, 5'h10, 1, 16'h0050, 8'h00};
        rows[9]  = '{1, 5'h00, 0, 0, 1, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h10, 0, 16'h0050, 8'hF0};
        rows[10] = '{1, 5'h00, 1, 0, 1, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h10, 0, 16'h0050, 8'h1F};
        rows[11] = '{1, 5'h00, 0, 1, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'h1F};
        rows[12] = '{1, 5'h00, 1, 1, 0, 8'h02, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'h1F};
        rows[13] = '{1, 5'h02, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h02, 0, 16'h0050, 8'h1F};
        rows[14] = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h02, 0, 16'h0050, 8'h1F};
        rows[15] = '{1, 5'h00, 0, 0, 1, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h02, 0, 16'h0050, 8'hE2};
        rows[16] = '{1, 5'h08, 0, 1, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'hE2};
        rows[17] = '{1, 5'h00, 0, 0, 1, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'hE8};
        rows[18] = '{0, 5'h01, 1, 1, 1, 8'h1F, 4'b0010, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'hE8};
        rows[19] = '{1, 5'h00, 1, 0, 1, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'h02};
        rows[20] = '{1, 5'h00, 1, 1, 0, 8'h01, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'h02};
        rows[21] = '{1, 5'h01, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h01, 0, 16'h0050, 8'h02};
        rows[22] = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b1001, 2'b00, 0, 0, 5'h01, 0, 16'h0050, 8'h02};
        rows[23] = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h01, 0, 16'h0050, 8'h02};
        rows[24] = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0001, 2'b00, 0, 1, 5'h01, 0, 16'h0050, 8'h02};
        rows[25] = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 1, 1, 5'h01, 0, 16'h0050, 8'h02};
        rows[26] = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b10, 0, 0, 5'h01, 0, 16'h0050, 8'h02};
        rows[27] = '{1, 5'h00, 1, 1, 0, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0050, 8'h02};
        rows[28] = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b01, 0, 0, 5'h00, 1, CAN_VEC,  8'h02};
        rows[29] = '{1, 5'h00, 0, 0, 1, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, CAN_VEC,  CAN_RD};

        // Reset-in-dispatch sequence: arm via RETI, ack, then reset before fetch.
        hand[0]  = '{1, 5'h01, 1, 1, 0, 8'h01, 4'b0010, 2'b00, 0, 1, 5'h01, 0, CAN_VEC,  CAN_RD};
        hand[1]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b00, 1, 1, 5'h01, 0, CAN_VEC,  CAN_RD};
        hand[2]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b10, 0, 0, 5'h01, 0, CAN_VEC,  CAN_RD};
        hand[3]  = '{1, 5'h00, 0, 0, 0, 8'h00, 4'b0000, 2'b01, 0, 0, 5'h00, 0, 16'h0000, 8'h00};
        hand[4]  = '{1, 5'h00, 0, 0, 1, 8'h00, 4'b0000, 2'b01, 0, 0, 5'h00, 0, 16'h0000, 8'hE0};
        hand[5]  = '{1, 5'h00, 1, 0, 1, 8'h00, 4'b0000, 2'b00, 0, 0, 5'h00, 0, 16'h0000, 8'h00};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset_state", 33'h0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) apply(rows[i], $sformatf("row%0d", i));

        for (int i = 0; i < 3; i++) apply(hand[i], $sformatf("dispatch_arm%0d", i));
        rst = 1'b1;
        #1;
        check_outputs("async_reset", 33'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 3; i < 6; i++) apply(hand[i], $sformatf("post_reset%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
